// File: rtl/centroid_divider_if.sv
// Bundle carrying the moment snapshot from the accumulators into the centroid
// divider and the registered centroid result back out.
//   master : accumulator/overlay side; drives eof and the moments, receives results
//   slave  : divider side
// Signals: eof, m00[DEN_W], m10/m01[NUM_W] in; acc_clr, busy, valid, found,
//          x_c/y_c[OUT_W], ovr out.
interface centroid_divider_if #(
  parameter int unsigned NUM_W = 30,
  parameter int unsigned DEN_W = 20,
  parameter int unsigned OUT_W = 11
);
  logic             eof;
  logic [DEN_W-1:0] m00;
  logic [NUM_W-1:0] m10;
  logic [NUM_W-1:0] m01;
  logic             acc_clr;
  logic             busy;
  logic             valid;
  logic             found;
  logic [OUT_W-1:0] x_c;
  logic [OUT_W-1:0] y_c;
  logic             ovr;

  modport master (
    output eof, m00, m10, m01,
    input  acc_clr, busy, valid, found, x_c, y_c, ovr
  );

  modport slave (
    input  eof, m00, m10, m01,
    output acc_clr, busy, valid, found, x_c, y_c, ovr
  );
endinterface

// File: rtl/centroid_divider.sv
// Centroid divider: on eof snapshots m00/m10/m01, pulses acc_clr, then computes
// x_c = m10/m00 and y_c = m01/m00 with two restoring dividers (one quotient bit
// per clock) and presents the saturated result with a one-cycle valid pulse.
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset
//   bus  : centroid_divider_if.slave (eof, moments in; acc_clr, busy, valid,
//          found, x_c, y_c, ovr out)
// Build option: define CENTROID_ROUND_EN to round the quotient to nearest
// (ties up) instead of truncating; adds one iteration of latency.
module centroid_divider #(
  parameter int unsigned NUM_W = 30,
  parameter int unsigned DEN_W = 20,
  parameter int unsigned OUT_W = 11
) (
  input logic                clk,
  input logic                rst,
  centroid_divider_if.slave  bus
);

`ifdef CENTROID_ROUND_EN
  // One extra numerator bit so that adding floor(m00/2) cannot overflow.
  localparam int unsigned QW = NUM_W + 1;
`else
  localparam int unsigned QW = NUM_W;
`endif
  localparam int unsigned CntW = $clog2(QW);

  typedef enum logic [1:0] {StIdle, StDiv, StDone} state_e;

  state_e           state_q, state_d;
  logic [DEN_W-1:0] den_q, den_d;
  // Numerator shift registers; quotient bits shift in at the LSB, so after QW
  // steps they hold the quotient.
  logic [QW-1:0]    x_num_q, x_num_d;
  logic [QW-1:0]    y_num_q, y_num_d;
  // The partial remainder is always < divisor, so DEN_W bits store it; the
  // shifted value used for the compare is DEN_W+1 bits wide.
  logic [DEN_W-1:0] x_rem_q, x_rem_d;
  logic [DEN_W-1:0] y_rem_q, y_rem_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             acc_clr_q, acc_clr_d;
  logic             busy_q, busy_d;
  logic             valid_q, valid_d;
  logic             found_q, found_d;
  logic [OUT_W-1:0] x_c_q, x_c_d;
  logic [OUT_W-1:0] y_c_q, y_c_d;
  logic             ovr_q, ovr_d;

  // One restoring-division step: returns {remainder, numerator/quotient}.
  function automatic logic [DEN_W+QW-1:0] div_step(input logic [DEN_W-1:0] rem,
                                                   input logic [QW-1:0]    num,
                                                   input logic [DEN_W-1:0] den);
    logic [DEN_W:0] sh;
    sh = {rem, num[QW-1]};
    if (sh >= {1'b0, den}) begin
      return {DEN_W'(sh - {1'b0, den}), num[QW-2:0], 1'b1};
    end else begin
      return {sh[DEN_W-1:0], num[QW-2:0], 1'b0};
    end
  endfunction

  function automatic logic [OUT_W-1:0] saturate(input logic [QW-1:0] q);
    if (|q[QW-1:OUT_W]) begin
      return '1;
    end else begin
      return q[OUT_W-1:0];
    end
  endfunction

  always_comb begin
    state_d   = state_q;
    den_d     = den_q;
    x_num_d   = x_num_q;
    y_num_d   = y_num_q;
    x_rem_d   = x_rem_q;
    y_rem_d   = y_rem_q;
    cnt_d     = cnt_q;
    acc_clr_d = 1'b0;
    busy_d    = busy_q;
    valid_d   = 1'b0;
    found_d   = found_q;
    x_c_d     = x_c_q;
    y_c_d     = y_c_q;
    ovr_d     = ovr_q;

    unique case (state_q)
      StIdle: begin
        if (bus.eof) begin
          den_d     = bus.m00;
`ifdef CENTROID_ROUND_EN
          x_num_d   = QW'(bus.m10) + QW'(bus.m00 >> 1);
          y_num_d   = QW'(bus.m01) + QW'(bus.m00 >> 1);
`else
          x_num_d   = bus.m10;
          y_num_d   = bus.m01;
`endif
          x_rem_d   = '0;
          y_rem_d   = '0;
          cnt_d     = CntW'(QW - 1);
          acc_clr_d = 1'b1;
          busy_d    = 1'b1;
          // Empty frame has nothing to divide; report straight away.
          state_d   = (bus.m00 == '0) ? StDone : StDiv;
        end
      end
      StDiv: begin
        {x_rem_d, x_num_d} = div_step(x_rem_q, x_num_q, den_q);
        {y_rem_d, y_num_d} = div_step(y_rem_q, y_num_q, den_q);
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (den_q != '0) begin
          x_c_d   = saturate(x_num_q);
          y_c_d   = saturate(y_num_q);
          found_d = 1'b1;
        end else begin
          found_d = 1'b0;
        end
        valid_d = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // A frame ending while the previous one is still in flight is dropped.
    if (bus.eof && (state_q != StIdle)) begin
      ovr_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      den_q     <= '0;
      x_num_q   <= '0;
      y_num_q   <= '0;
      x_rem_q   <= '0;
      y_rem_q   <= '0;
      cnt_q     <= '0;
      acc_clr_q <= 1'b0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      found_q   <= 1'b0;
      x_c_q     <= '0;
      y_c_q     <= '0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      den_q     <= den_d;
      x_num_q   <= x_num_d;
      y_num_q   <= y_num_d;
      x_rem_q   <= x_rem_d;
      y_rem_q   <= y_rem_d;
      cnt_q     <= cnt_d;
      acc_clr_q <= acc_clr_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
      found_q   <= found_d;
      x_c_q     <= x_c_d;
      y_c_q     <= y_c_d;
      ovr_q     <= ovr_d;
    end
  end

  assign bus.acc_clr = acc_clr_q;
  assign bus.busy    = busy_q;
  assign bus.valid   = valid_q;
  assign bus.found   = found_q;
  assign bus.x_c     = x_c_q;
  assign bus.y_c     = y_c_q;
  assign bus.ovr     = ovr_q;

endmodule

// File: tb/tb_centroid_divider.sv
// Directed self-checking bench for centroid_divider.
module tb_centroid_divider;
  localparam int unsigned NUM_W = 30;
  localparam int unsigned DEN_W = 20;
  localparam int unsigned OUT_W = 11;

`ifdef CENTROID_ROUND_EN
  localparam int LAT    = 32;
  localparam int FULL_X = 640;
  localparam int FULL_Y = 360;
  localparam int MIX_Y  = 4;
  localparam int RST_X  = 11;
`else
  localparam int LAT    = 31;
  localparam int FULL_X = 639;
  localparam int FULL_Y = 359;
  localparam int MIX_Y  = 3;
  localparam int RST_X  = 10;
`endif

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  int   acc_cnt;
  int   valid_cnt;

  centroid_divider_if #(.NUM_W(NUM_W), .DEN_W(DEN_W), .OUT_W(OUT_W)) bus ();

  centroid_divider #(.NUM_W(NUM_W), .DEN_W(DEN_W), .OUT_W(OUT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.acc_clr) acc_cnt++;
    if (bus.valid) valid_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Caller is just after a posedge; eof is sampled at the next edge (edge N).
  task automatic drive_eof(input int m00, input int m10, input int m01);
    bus.eof = 1'b1;
    bus.m00 = DEN_W'(m00);
    bus.m10 = NUM_W'(m10);
    bus.m01 = NUM_W'(m01);
    @(posedge clk);
    #1;
    bus.eof = 1'b0;
  endtask

  task automatic apply_eof(input int m00, input int m10, input int m01);
    @(posedge clk);
    #1;
    drive_eof(m00, m10, m01);
  endtask

  // Returns edges after edge N until valid is seen (max_cyc if never).
  task automatic wait_valid(input int max_cyc, output int lat);
    lat = max_cyc;
    for (int i = 1; i <= max_cyc; i++) begin
      @(posedge clk);
      #1;
      if (bus.valid) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check_eq({tag, "_acc_clr"}, 32'(bus.acc_clr), 0);
    check_eq({tag, "_busy"}, 32'(bus.busy), 0);
    check_eq({tag, "_valid"}, 32'(bus.valid), 0);
    check_eq({tag, "_found"}, 32'(bus.found), 0);
    check_eq({tag, "_x_c"}, 32'(bus.x_c), 0);
    check_eq({tag, "_y_c"}, 32'(bus.y_c), 0);
    check_eq({tag, "_ovr"}, 32'(bus.ovr), 0);
  endtask

  task automatic run_frame(input string tag, input int m00, input int m10, input int m01,
                           input int exp_lat, input int exp_x, input int exp_y,
                           input int exp_found);
    int lat;
    apply_eof(m00, m10, m01);
    check_eq({tag, "_acc_clr"}, 32'(bus.acc_clr), 1);
    check_eq({tag, "_busy"}, 32'(bus.busy), 1);
    wait_valid(LAT + 5, lat);
    check_eq({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check_eq({tag, "_x_c"}, 32'(bus.x_c), 32'(exp_x));
    check_eq({tag, "_y_c"}, 32'(bus.y_c), 32'(exp_y));
    check_eq({tag, "_found"}, 32'(bus.found), 32'(exp_found));
    check_eq({tag, "_busy_done"}, 32'(bus.busy), 0);
  endtask

  initial begin
    int lat;
    int acc0;
    int val0;
    n_checks  = 0;
    n_errors  = 0;
    acc_cnt   = 0;
    valid_cnt = 0;
    rst     = 1'b1;
    bus.eof = 1'b0;
    bus.m00 = '0;
    bus.m10 = '0;
    bus.m01 = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_idle_zero("reset");

    // Single pixel.
    run_frame("single", 1, 100, 50, LAT, 100, 50, 1);
    @(posedge clk);
    #1;
    check_eq("single_valid_pulse", 32'(bus.valid), 0);
    check_eq("single_acc_cnt", 32'(acc_cnt), 1);

    // Quotient larger than the output width saturates.
    run_frame("sat", 1, 5000, 3000, LAT, 2047, 2047, 1);
    // Non-exact quotients.
    run_frame("mix", 3, 10, 11, LAT, 3, MIX_Y, 1);
    // Full frame, quotient exactly .5.
    run_frame("full", 921600, 589363200, 331315200, LAT, FULL_X, FULL_Y, 1);

    // Empty frame: immediate valid, previous centroid held.
    acc0 = acc_cnt;
    run_frame("empty", 0, 777, 777, 1, FULL_X, FULL_Y, 0);
    @(posedge clk);
    #1;
    check_eq("empty_acc_cnt", 32'(acc_cnt - acc0), 1);

    // Overrun: second eof 10 cycles after the first is dropped.
    acc0 = acc_cnt;
    val0 = valid_cnt;
    apply_eof(2, 300, 80);
    repeat (9) @(posedge clk);
    #1;
    drive_eof(5, 1000, 1000);
    check_eq("ovr_set", 32'(bus.ovr), 1);
    wait_valid(LAT + 5, lat);
    check_eq("ovr_lat", 32'(lat), 32'(LAT - 10));
    check_eq("ovr_x_c", 32'(bus.x_c), 150);
    check_eq("ovr_y_c", 32'(bus.y_c), 40);
    repeat (LAT + 5) @(posedge clk);
    #1;
    check_eq("ovr_acc_cnt", 32'(acc_cnt - acc0), 1);
    check_eq("ovr_valid_cnt", 32'(valid_cnt - val0), 1);
    check_eq("ovr_sticky", 32'(bus.ovr), 1);

    // Reset in the middle of a division.
    apply_eof(1, 100, 50);
    repeat (14) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_idle_zero("midrst");
    val0 = valid_cnt;
    repeat (LAT + 5) @(posedge clk);
    #1;
    check_eq("midrst_no_valid", 32'(valid_cnt - val0), 0);
    run_frame("after_rst", 4, 42, 8, LAT, RST_X, 2, 1);

    // Back-to-back: eof during the valid cycle is accepted.
    run_frame("b2b_first", 2, 300, 80, LAT, 150, 40, 1);
    drive_eof(3, 10, 11);
    check_eq("b2b_acc_clr", 32'(bus.acc_clr), 1);
    wait_valid(LAT + 5, lat);
    check_eq("b2b_lat", 32'(lat), 32'(LAT));
    check_eq("b2b_x_c", 32'(bus.x_c), 3);
    check_eq("b2b_y_c", 32'(bus.y_c), 32'(MIX_Y));
    check_eq("b2b_ovr", 32'(bus.ovr), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/centroid_divider.md
Name: centroid_divider

Overview:
Consumer side of the per-frame moment accumulators in the centroid pipeline. On the end-of-frame strobe it snapshots the accumulated moments m00, m10 and m01, then pulses a clear to the accumulators. It computes x_c = m10/m00 and y_c = m01/m00 with two parallel iterative restoring dividers at one quotient bit per clock. It then presents the registered centroid with a one-cycle valid pulse to the marker/overlay logic.

Parameters:
NUM_W, 30, width of m10/m01 moment inputs and of the quotient before narrowing
DEN_W, 20, width of m00 pixel count (1280*720 = 921600 < 2^20)
OUT_W, 11, width of x_c/y_c outputs

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
eof  in  1  end-of-frame strobe, one cycle; moments valid in the same cycle
m00  in  DEN_W  count of object pixels in frame
m10  in  NUM_W  sum of x positions of object pixels
m01  in  NUM_W  sum of y positions of object pixels
acc_clr  out  1  one-cycle clear pulse to the moment accumulators
busy  out  1  high while a division is in progress
valid  out  1  one-cycle pulse: x_c/y_c/found updated
found  out  1  1 = m00 was non-zero for the latest frame
x_c  out  OUT_W  centroid x, held between frames
y_c  out  OUT_W  centroid y, held between frames
ovr  out  1  sticky: eof arrived while busy; cleared only by rst

Behaviour:
- Reset (rst=1 at posedge): state=IDLE. acc_clr, busy, valid, found, x_c, y_c and ovr all go to 0. Internal operand, remainder and count registers go to 0. Reset mid-division aborts it; no valid pulse follows.
- States: IDLE, DIV, DONE.
- IDLE + eof sampled at edge N:
  - latch m00, m10, m01; acc_clr=1 for the cycle after edge N; busy=1; go to DIV with bit counter = NUM_W-1.
  - if latched m00==0, skip DIV and go directly to DONE.
- DIV, per edge:
  - both dividers shift remainder left by 1, bringing in the next numerator bit, MSB first.
  - if remainder >= divisor: subtract and set that quotient bit to 1; else set it to 0.
  - counter decrements; after the NUM_W-th iteration go to DONE.
- DONE, one edge:
  - m00!=0: x_c/y_c <= quotient; if quotient > 2^OUT_W-1, saturate to all ones. found <= 1.
  - m00==0: x_c/y_c hold their previous values; found <= 0.
  - valid=1 for exactly one cycle; busy <= 0; go to IDLE.
- Latency: eof at edge N → valid high after edge N+NUM_W+1 (31 cycles by default). For m00==0 → valid after edge N+1.
- Remainder width: DEN_W+1 bits, so the compare never overflows.
- eof while busy (DIV or DONE): ignored, no snapshot, no acc_clr; ovr <= 1. eof in the cycle valid is high (state IDLE) is accepted normally.
- acc_clr is asserted exactly once per accepted eof, independent of m00.
- Inputs are sampled only on the accepted eof edge; changes afterwards do not affect the result.

Optional Feature:
- Macro CENTROID_ROUND_EN.
- Defined: each numerator is extended to NUM_W+1 bits and has floor(m00/2) added before division. Result rounds to nearest, ties up. Iteration count becomes NUM_W+1, so latency is 32 cycles.
- Undefined: quotient truncates toward zero; latency is NUM_W+1 = 31 cycles.

Test Plan:
- Single pixel: m00=1, m10=100, m01=50, eof pulse → acc_clr 1 cycle after eof; valid 31 cycles after eof; x_c=100, y_c=50, found=1.
- Full frame: m00=921600, m10=589363200, m01=331315200 → x_c=639, y_c=359 (with CENTROID_ROUND_EN: 640, 360; valid at 32 cycles).
- Empty frame following the full frame: m00=0, eof → valid the cycle after eof; found=0; x_c/y_c hold 639/359; acc_clr still pulses.
- Overrun: eof, then second eof 10 cycles later with different moments → first result correct; no second acc_clr or valid; ovr=1 until rst.
- Reset mid-division: eof, rst asserted at cycle 15 → all outputs 0, no valid pulse; next eof with m00=4, m10=42, m01=8 → x_c=10, y_c=2.
- Back-to-back: eof asserted in the same cycle as valid → accepted; second result correct after a further 31 cycles; ovr stays 0.
